// File: rtl/seq_ctrl_if.sv
// Memory-side bus of the instruction sequencer: instruction fetch port and
// data access port.
//
// Handshake semantics (both ports): the requester raises *_req and holds it,
// together with its address/direction qualifiers, every cycle until it samples
// the matching *_ack high on a rising clk edge. An ack may arrive in the same
// cycle the request first rises. An ack while no request is outstanding has no
// effect. Data returned with an ack (imem_rdata) is valid only in that ack
// cycle.
interface seq_ctrl_if #(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 16
) ();
  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;
  logic               dmem_req;
  logic               dmem_we;
  logic               dmem_ack;

  // Sequencer side: issues requests, receives acks and fetched data.
  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata,
    output dmem_req,
    output dmem_we,
    input  dmem_ack
  );

  // Memory side: receives requests, answers with acks and fetched data.
  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata,
    input  dmem_req,
    input  dmem_we,
    output dmem_ack
  );
endinterface

// File: rtl/seq_ctrl.sv
// Multi-cycle instruction sequencer. Owns pc and ir and walks each instruction
// through FETCH/DECODE/EXEC/MEM/WB, issuing one datapath strobe per cycle.
// Opcode map: 0..6 ALU ops, 7 LOAD, 8 STORE, 9..E undefined (retired as NOP,
// sticky illegal flag), F HALT.
module seq_ctrl #(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  seq_ctrl_if.master         bus,
  output logic [INSTR_W-1:0] ir,
  output logic [PC_W-1:0]    pc,
  output logic               alu_en,
  output logic               rf_we,
  output logic               retire,
  output logic               halted,
  output logic               illegal,
  output logic [2:0]         state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_e;

  localparam logic [3:0] OP_LOAD  = 4'h7;
  localparam logic [3:0] OP_STORE = 4'h8;
  localparam logic [3:0] OP_HALT  = 4'hF;

  state_e     state;
  state_e     state_nxt;
  logic [3:0] op;

  // Register update requests produced by the next-state logic.
  logic ir_load;
  logic pc_inc;
  logic set_illegal;
  logic set_halt;

  // Local copies of the bus strobes so the decode reads as one block.
  logic imem_req_w;
  logic dmem_req_w;
  logic dmem_we_w;

  assign op        = ir[INSTR_W-1 -: 4];
  assign state_dbg = state;

  assign bus.imem_req  = imem_req_w;
  assign bus.imem_addr = pc;
  assign bus.dmem_req  = dmem_req_w;
  assign bus.dmem_we   = dmem_we_w;

  // State, pc, ir and the sticky status flags; rst wins over everything,
  // including an ack arriving in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      pc      <= '0;
      ir      <= '0;
      halted  <= 1'b0;
      illegal <= 1'b0;
    end else begin
      state <= state_nxt;
      if (ir_load)     ir      <= bus.imem_rdata;
      if (pc_inc)      pc      <= pc + PC_W'(1);
      if (set_illegal) illegal <= 1'b1;
      if (set_halt)    halted  <= 1'b1;
    end
  end

  // Next-state routing plus per-state strobes. Strobes depend only on the
  // registered state and ir, except the STORE retire which lands in the
  // dmem_ack cycle itself.
  always_comb begin
    state_nxt   = state;
    ir_load     = 1'b0;
    pc_inc      = 1'b0;
    set_illegal = 1'b0;
    set_halt    = 1'b0;
    imem_req_w  = 1'b0;
    dmem_req_w  = 1'b0;
    dmem_we_w   = 1'b0;
    alu_en      = 1'b0;
    rf_we       = 1'b0;
    retire      = 1'b0;
    case (state)
      S_IDLE: begin
        state_nxt = S_FETCH;
      end
      S_FETCH: begin
        imem_req_w = 1'b1;
        if (bus.imem_ack) begin
          ir_load   = 1'b1;
          state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        if (op == OP_HALT) begin
          set_halt  = 1'b1;
          state_nxt = S_HALT;
        end else if (op <= OP_STORE) begin
          state_nxt = S_EXEC;
        end else begin
          // Undefined opcode: retire it as a NOP and remember it happened.
          set_illegal = 1'b1;
          pc_inc      = 1'b1;
          retire      = 1'b1;
          state_nxt   = S_FETCH;
        end
      end
      S_EXEC: begin
        alu_en    = 1'b1;
        state_nxt = ((op == OP_LOAD) || (op == OP_STORE)) ? S_MEM : S_WB;
      end
      S_MEM: begin
        dmem_req_w = 1'b1;
        dmem_we_w  = (op == OP_STORE);
        if (bus.dmem_ack) begin
          if (op == OP_STORE) begin
            // Stores have nothing to write back, so they complete here.
            pc_inc    = 1'b1;
            retire    = 1'b1;
            state_nxt = S_FETCH;
          end else begin
            state_nxt = S_WB;
          end
        end
      end
      S_WB: begin
        rf_we     = 1'b1;
        retire    = 1'b1;
        pc_inc    = 1'b1;
        state_nxt = S_FETCH;
      end
      S_HALT: begin
        state_nxt = S_HALT;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // The four unit strobes never overlap.
  always @(posedge clk) begin
    if (!rst) begin
      assert ($countones({imem_req_w, dmem_req_w, alu_en, rf_we}) <= 1)
        else $error("seq_ctrl: overlapping unit strobes");
    end
  end

endmodule

// File: tb/tb_seq_ctrl.sv
// Bench for seq_ctrl. The model describes each instruction as the list of
// cycles it must occupy (fetch waits, decode, exec, memory waits, writeback)
// with the strobes and register values each cycle must show, plus the memory
// inputs to drive in that cycle. A trace runner replays that list cycle by
// cycle against the DUT.
module tb_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] ir;
  logic [7:0]  pc;
  logic        alu_en;
  logic        rf_we;
  logic        retire;
  logic        halted;
  logic        illegal;
  logic [2:0]  state_dbg;

  int tests_run    = 0;
  int tests_failed = 0;

  seq_ctrl_if #(.PC_W(8), .INSTR_W(16)) bus ();

  seq_ctrl #(.PC_W(8), .INSTR_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .ir        (ir),
    .pc        (pc),
    .alu_en    (alu_en),
    .rf_we     (rf_we),
    .retire    (retire),
    .halted    (halted),
    .illegal   (illegal),
    .state_dbg (state_dbg)
  );

  // ---------------------------------------------------------------- clock
  always #5 clk = ~clk;

  // ------------------------------------------------------------ scoreboard
  // Per-cycle expectation:
  //   {imem_req, dmem_req, dmem_we, alu_en, rf_we, retire, halted, illegal,
  //    pc, imem_addr, ir}
  logic [39:0] exp_q[$];
  bit          ia_q[$];
  logic [15:0] rd_q[$];
  bit          da_q[$];

  // Architectural model state.
  logic [7:0]  m_pc;
  logic [15:0] m_ir;
  bit          m_ill;
  bit          m_halt;
  bit          noise_en = 1'b1;
  int          last_retire_cyc;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit noise();
    return noise_en && ($urandom_range(0, 3) == 0);
  endfunction

  task automatic push(input bit ia, input logic [15:0] rd, input bit da,
                      input bit ireq, input bit dreq, input bit dwe,
                      input bit alu, input bit rfwe, input bit ret);
    exp_q.push_back({ireq, dreq, dwe, alu, rfwe, ret, m_halt, m_ill, m_pc, m_pc, m_ir});
    ia_q.push_back(ia);
    rd_q.push_back(rd);
    da_q.push_back(da);
  endtask

  function automatic logic [15:0] rnd16();
    return 16'($urandom);
  endfunction

  // Cycles of a non-FETCH, non-MEM state: stray acks are allowed on both ports.
  task automatic push_plain(input bit alu, input bit rfwe, input bit ret);
    push(noise(), rnd16(), noise(), 1'b0, 1'b0, 1'b0, alu, rfwe, ret);
  endtask

  task automatic model_reset();
    m_pc   = 8'h00;
    m_ir   = 16'h0000;
    m_ill  = 1'b0;
    m_halt = 1'b0;
    push_plain(1'b0, 1'b0, 1'b0);   // the IDLE cycle
  endtask

  // One instruction: wi fetch wait cycles, wd data wait cycles.
  task automatic model_instr(input logic [15:0] instr, input int wi, input int wd);
    logic [3:0] op;
    op = instr[15:12];
    for (int k = 0; k < wi; k++) push(1'b0, rnd16(), noise(), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    push(1'b1, instr, noise(), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    m_ir = instr;
    if (op == 4'hF) begin
      push_plain(1'b0, 1'b0, 1'b0);
      m_halt = 1'b1;
    end else if (op >= 4'h9) begin
      push_plain(1'b0, 1'b0, 1'b1);
      m_ill = 1'b1;
      m_pc  = m_pc + 8'd1;
    end else begin
      push_plain(1'b0, 1'b0, 1'b0);        // decode
      push_plain(1'b1, 1'b0, 1'b0);        // exec
      if (op <= 4'h6) begin
        push_plain(1'b0, 1'b1, 1'b1);      // writeback
        m_pc = m_pc + 8'd1;
      end else begin
        for (int k = 0; k < wd; k++)
          push(noise(), rnd16(), 1'b0, 1'b0, 1'b1, (op == 4'h8), 1'b0, 1'b0, 1'b0);
        push(noise(), rnd16(), 1'b1, 1'b0, 1'b1, (op == 4'h8), 1'b0, 1'b0, (op == 4'h8));
        if (op == 4'h7) push_plain(1'b0, 1'b1, 1'b1);
        m_pc = m_pc + 8'd1;
      end
    end
  endtask

  // ----------------------------------------------------------- driver tasks
  // Called at #1 after a rising edge; returns at #1 after a rising edge.
  task automatic run_trace(input string tag);
    logic [39:0] e;
    logic [39:0] got;
    int cyc;
    cyc = 0;
    last_retire_cyc = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      bus.imem_ack   = ia_q.pop_front();
      bus.imem_rdata = rd_q.pop_front();
      bus.dmem_ack   = da_q.pop_front();
      cyc++;
      @(negedge clk);
      got = {bus.imem_req, bus.dmem_req, bus.dmem_we, alu_en, rf_we, retire,
             halted, illegal, pc, bus.imem_addr, ir};
      check(tag, 64'(got), 64'(e));
      if (retire && last_retire_cyc == 0) last_retire_cyc = cyc;
      @(posedge clk);
      #1;
    end
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
  endtask

  // Three reset edges with a fetch ack pending; leaves rst released and the
  // IDLE cycle queued in the model.
  task automatic do_reset();
    rst            = 1'b1;
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 16'h7777;
    bus.dmem_ack   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      if (i < 2) begin
        @(negedge clk);
        check("rst_strobes", 64'({bus.imem_req, bus.dmem_req, bus.dmem_we, alu_en, rf_we, retire}), 64'd0);
        check("rst_regs", 64'({pc, ir, halted, illegal}), 64'd0);
      end
    end
    rst          = 1'b0;
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
    exp_q.delete();
    ia_q.delete();
    rd_q.delete();
    da_q.delete();
    model_reset();
  endtask

  // -------------------------------------------------------------- stimulus
  initial begin
    logic [3:0]  op;
    logic [15:0] instr;
    bit          wrapped;
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = 16'h0000;
    bus.dmem_ack   = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset, then get stuck in FETCH and reset again mid-handshake.
    do_reset();
    for (int k = 0; k < 3; k++) push(1'b0, rnd16(), noise(), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_trace("reset_fetch");
    do_reset();
    run_trace("idle");

    // ADD, zero wait.
    model_instr(16'h0123, 0, 0);
    run_trace("add");
    check("add_latency", 64'(last_retire_cyc), 64'd4);
    check("add_pc", 64'(pc), 64'd1);

    // LOAD with a 3-cycle data wait.
    model_instr(16'h7120, 0, 3);
    run_trace("load");
    check("load_latency", 64'(last_retire_cyc), 64'd8);
    check("load_pc", 64'(pc), 64'd2);

    // STORE, zero wait.
    model_instr(16'h8120, 0, 0);
    run_trace("store");
    check("store_latency", 64'(last_retire_cyc), 64'd4);
    check("store_pc", 64'(pc), 64'd3);

    // Undefined opcode retires as a NOP and sets the sticky flag.
    model_instr(16'hA5A5, 1, 0);
    run_trace("illegal_nop");
    check("illegal_flag", 64'(illegal), 64'd1);
    check("illegal_pc", 64'(pc), 64'd4);

    // Random stream, long enough to carry pc through 8'hFF.
    wrapped = 1'b0;
    for (int n = 0; n < 300; n++) begin
      op = 4'($urandom_range(0, 14));
      if (m_pc == 8'hFF) op = 4'h1;
      instr = {op, 12'($urandom)};
      model_instr(instr, $urandom_range(0, 2), $urandom_range(0, 3));
      if (m_pc == 8'h00) begin
        run_trace("random_wrap");
        check("wrap_pc", 64'(pc), 64'd0);
        wrapped = 1'b1;
      end else begin
        run_trace("random");
      end
    end
    check("wrap_seen", 64'(wrapped), 64'd1);
    check("illegal_sticky", 64'(illegal), 64'd1);

    // HALT: frozen for 20 cycles whatever the memories do.
    model_instr(16'hF000, 0, 0);
    for (int k = 0; k < 20; k++) push_plain(1'b0, 1'b0, 1'b0);
    run_trace("halt");
    check("halt_flag", 64'(halted), 64'd1);
    check("halt_pc", 64'(pc), 64'(m_pc));

    // ----------------------------------------------------------- report
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
